// File: rtl/comp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    CMP_UNSIGNED = 2'd0,
    CMP_SIGNED   = 2'd1,
    CMP_SIGNMAG  = 2'd2,
    CMP_RSVD     = 2'd3
  } comp_mode_e;

  localparam int unsigned DEFAULT_CHUNK = 4;

  typedef struct packed {
    logic less;
    logic equal;
    logic greater;
  } comp_res_t;

  function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational less/equal compare of one CHUNK-bit slice.
module comp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             less_c,
  output logic             equal_c
);

  assign less_c  = (a < b);
  assign equal_c = (a == b);

endmodule

// File: rtl/comp_pipe.sv
// Two-stage elastic magnitude comparator: chunked compare in stage 1,
// priority resolve and sign handling in stage 2.
module comp_pipe
  import comp_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 28,
  parameter int unsigned CHUNK     = DEFAULT_CHUNK
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_less,
  output logic                 o_equal,
  output logic                 o_greater
);

  localparam int unsigned NCHUNK = cdiv(SIZE_DATA, CHUNK);
  localparam int unsigned WEXT   = NCHUNK * CHUNK;
  localparam int unsigned MSB    = SIZE_DATA - 1;

  comp_mode_e           mode_in;
  logic [SIZE_DATA-1:0] tr_a;
  logic [SIZE_DATA-1:0] tr_b;
  logic [WEXT-1:0]      ext_a;
  logic [WEXT-1:0]      ext_b;
  logic [NCHUNK-1:0]    lt_c;
  logic [NCHUNK-1:0]    eq_c;

  logic                 v1;
  logic                 v2;
  logic                 en1;
  logic                 en2;
  logic [NCHUNK-1:0]    lt_q;
  logic [NCHUNK-1:0]    eq_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic                 mz_a_q;
  logic                 mz_b_q;
  comp_mode_e           mode_q;

  logic                 lt_chain;
  logic                 eq_chain;
  comp_res_t            res_c;
  comp_res_t            res_q;

  // Operand transform: reserved mode behaves as unsigned; signed flips MSB; sign-mag drops it
  always_comb begin
    mode_in = (i_mode == 2'b11) ? CMP_UNSIGNED : comp_mode_e'(i_mode);
    tr_a    = i_data_a;
    tr_b    = i_data_b;
    case (mode_in)
      CMP_SIGNED: begin
        tr_a[MSB] = ~i_data_a[MSB];
        tr_b[MSB] = ~i_data_b[MSB];
      end
      CMP_SIGNMAG: begin
        tr_a[MSB] = 1'b0;
        tr_b[MSB] = 1'b0;
      end
      default: ;
    endcase
  end

  assign ext_a = WEXT'(tr_a);
  assign ext_b = WEXT'(tr_b);

  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (ext_a[g*CHUNK +: CHUNK]),
      .b       (ext_b[g*CHUNK +: CHUNK]),
      .less_c  (lt_c[g]),
      .equal_c (eq_c[g])
    );
  end

  assign en2     = ~v2 | i_ready;
  assign en1     = ~v1 | en2;
  assign o_ready = en1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1       <= 1'b0;
      lt_q     <= '0;
      eq_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mz_a_q   <= 1'b0;
      mz_b_q   <= 1'b0;
      mode_q   <= CMP_UNSIGNED;
    end else if (en1) begin
      v1 <= i_valid;
      if (i_valid) begin
        lt_q     <= lt_c;
        eq_q     <= eq_c;
        sign_a_q <= i_data_a[MSB];
        sign_b_q <= i_data_b[MSB];
        mz_a_q   <= ~|i_data_a[MSB-1:0];
        mz_b_q   <= ~|i_data_b[MSB-1:0];
        mode_q   <= mode_in;
      end
    end
  end

  // Priority chain from the most significant chunk down
  always_comb begin
    lt_chain = 1'b0;
    eq_chain = 1'b1;
    for (int i = int'(NCHUNK) - 1; i >= 0; i--) begin
      lt_chain = lt_chain | (eq_chain & lt_q[i]);
      eq_chain = eq_chain & eq_q[i];
    end
  end

  always_comb begin
    res_c = '0;
    if (mode_q == CMP_SIGNMAG) begin
      if (mz_a_q && mz_b_q) begin
        res_c.equal = 1'b1;
      end else if (sign_a_q != sign_b_q) begin
        res_c.less    = sign_a_q;
        res_c.greater = ~sign_a_q;
      end else if (sign_a_q) begin
        res_c.less    = ~lt_chain & ~eq_chain;
        res_c.equal   = eq_chain;
        res_c.greater = lt_chain;
      end else begin
        res_c.less    = lt_chain;
        res_c.equal   = eq_chain;
        res_c.greater = ~lt_chain & ~eq_chain;
      end
    end else begin
      res_c.less    = lt_chain;
      res_c.equal   = eq_chain;
      res_c.greater = ~lt_chain & ~eq_chain;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2    <= 1'b0;
      res_q <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        res_q <= res_c;
      end
    end
  end

  assign o_valid   = v2;
  assign o_less    = res_q.less;
  assign o_equal   = res_q.equal;
  assign o_greater = res_q.greater;

endmodule

// File: tb/tb_comp_pipe.sv
// Directed bench for comp_pipe: modes, widths, backpressure and reset.
module tb_comp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] data_a = '0;
  logic [27:0] data_b = '0;
  logic [1:0]  mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        less, equal, greater;

  logic        in_valid27 = 1'b0;
  logic        in_ready27;
  logic [26:0] data_a27 = '0;
  logic [26:0] data_b27 = '0;
  logic        out_valid27;
  logic        less27, equal27, greater27;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_pipe #(.SIZE_DATA(28), .CHUNK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(in_ready),
    .i_data_a(data_a), .i_data_b(data_b), .i_mode(mode),
    .o_valid(out_valid), .i_ready(out_ready),
    .o_less(less), .o_equal(equal), .o_greater(greater)
  );

  comp_pipe #(.SIZE_DATA(27), .CHUNK(4)) dut27 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid27), .o_ready(in_ready27),
    .i_data_a(data_a27), .i_data_b(data_b27), .i_mode(2'b00),
    .o_valid(out_valid27), .i_ready(1'b1),
    .o_less(less27), .o_equal(equal27), .o_greater(greater27)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge; exp is {less, equal, greater}
  task automatic run_pair(input string tag, input logic [27:0] a, input logic [27:0] b,
                          input logic [1:0] m, input logic [2:0] exp);
    data_a    = a;
    data_b    = b;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'({less, equal, greater}), 32'(exp));
    @(posedge clk); #1;
  endtask

  logic [27:0] va [5];
  logic [27:0] vb [5];
  logic [2:0]  ve [5];
  logic [2:0]  expq [$];
  logic [2:0]  cur;
  logic [2:0]  front;
  logic        acc, emt, held;
  int          sent, recv;
  bit          dropped;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({less, equal, greater}), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    run_pair("u_lt",    28'h0FFFFFF, 28'h1000000, 2'b00, 3'b100);
    run_pair("u_eq",    28'hABCDEF0, 28'hABCDEF0, 2'b00, 3'b010);
    run_pair("s_minlt", 28'h8000000, 28'h0000001, 2'b01, 3'b100);
    run_pair("s_m1gt",  28'hFFFFFFF, 28'hFFFFFFE, 2'b01, 3'b001);
    run_pair("sm_zero", 28'h8000000, 28'h0000000, 2'b10, 3'b010);
    run_pair("sm_neg",  28'h8000005, 28'h8000003, 2'b10, 3'b100);
    run_pair("sm_diff", 28'h0000001, 28'h8000009, 2'b10, 3'b001);
    run_pair("rsvd_u",  28'h8000000, 28'h0000001, 2'b11, 3'b001);

    // Non-multiple width instance
    data_a27   = 27'h4000000;
    data_b27   = 27'h3FFFFFF;
    in_valid27 = 1'b1;
    #1;
    check("w27_ready", 32'(in_ready27), 32'd1);
    @(posedge clk); #1;
    in_valid27 = 1'b0;
    @(posedge clk); #1;
    check("w27_valid", 32'(out_valid27), 32'd1);
    check("w27_res", 32'({less27, equal27, greater27}), 32'b001);
    @(posedge clk); #1;

    // Backpressure stream with i_ready pattern 1,0,0,1
    va[0] = 28'h0000001; vb[0] = 28'h0000002; ve[0] = 3'b100;
    va[1] = 28'h0000005; vb[1] = 28'h0000005; ve[1] = 3'b010;
    va[2] = 28'h0000009; vb[2] = 28'h0000003; ve[2] = 3'b001;
    va[3] = 28'h0000000; vb[3] = 28'hFFFFFFF; ve[3] = 3'b100;
    va[4] = 28'hFFFFFFF; vb[4] = 28'h0000000; ve[4] = 3'b001;
    sent = 0;
    recv = 0;
    dropped = 1'b0;
    mode = 2'b00;
    for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
      in_valid = (sent < 5);
      if (sent < 5) begin
        data_a = va[sent];
        data_b = vb[sent];
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      check("bp_oready", 32'(in_ready),
            32'(!(expq.size() == 2 && !out_ready)));
      if (!in_ready) dropped = 1'b1;
      acc  = in_valid && in_ready;
      emt  = out_valid && out_ready;
      held = out_valid && !out_ready;
      cur  = {less, equal, greater};
      @(posedge clk); #1;
      if (emt) begin
        check("bp_nodup", 32'(expq.size() > 0), 32'd1);
        front = (expq.size() > 0) ? expq.pop_front() : 3'b000;
        check("bp_order", 32'(cur), 32'(front));
        recv++;
      end else if (held) begin
        check("bp_hold_v", 32'(out_valid), 32'd1);
        check("bp_hold_r", 32'({less, equal, greater}), 32'(cur));
      end
      if (acc) begin
        expq.push_back(ve[sent]);
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd5);
    check("bp_recv", 32'(recv), 32'd5);
    check("bp_empty", 32'(expq.size()), 32'd0);
    check("bp_dropped", 32'(dropped), 32'd1);
    @(posedge clk); #1;
    check("bp_idle", 32'(out_valid), 32'd0);

    // Fill both stages, then reset asynchronously
    out_ready = 1'b0;
    data_a    = 28'h0000009;
    data_b    = 28'h0000001;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    data_a = 28'h0000007;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_flags", 32'({less, equal, greater}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);
    run_pair("post_rst", 28'h0000002, 28'h0000003, 2'b00, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_pipe.md
# comp_pipe

Parametrised, two-stage pipelined magnitude comparator for the floating-point datapath, successor to the fixed 28-bit combinational comparator. It compares two SIZE_DATA-bit operands in unsigned, two's-complement or sign-magnitude (IEEE-style, +0 == −0) mode, and returns exactly one of less/equal/greater. Operands enter and results leave through valid/ready handshakes with full throughput and backpressure. It sits between the exponent/mantissa alignment logic and the swap/select stage of the adder and the FP compare unit.

## Interface
- SIZE_DATA, 28: operand width, ≥ 2.
- CHUNK, 4: chunk width of the first-level compare, 1..SIZE_DATA; SIZE_DATA need not be a multiple of it.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  operand pair present.
- o_ready  out  1  block accepts the pair this cycle.
- i_data_a  in  SIZE_DATA  operand A.
- i_data_b  in  SIZE_DATA  operand B.
- i_mode  in  2  compare mode: 00 unsigned, 01 two's complement, 10 sign-magnitude, 11 reserved (treated as 00).
- o_valid  out  1  result present.
- i_ready  in  1  downstream accepts the result.
- o_less  out  1  A < B.
- o_equal  out  1  A == B.
- o_greater  out  1  A > B.

## Operation
- Input transform, combinational before stage 1:
  - Unsigned: operands pass through.
  - Two's complement: invert the MSB of both operands, then compare unsigned.
  - Sign-magnitude: strip the MSB as the sign. Magnitudes are the low SIZE_DATA−1 bits, zero-extended.
- Transformed operands are zero-extended at the MSB end to NCHUNK·CHUNK bits, with NCHUNK = ceil(SIZE_DATA/CHUNK).
- Stage 1 registers:
  - per-chunk less[NCHUNK] and equal[NCHUNK];
  - sign_a, sign_b, mag_zero_a, mag_zero_b;
  - the mode.
- Stage 2 resolves a priority chain from the MSB chunk down. Lt is true when some chunk i has less[i] and every higher chunk is equal. Eq is the AND of all equal[i].
- Sign-magnitude result:
  - both magnitudes zero → equal, regardless of signs;
  - signs differ → A is negative ⇒ less, else greater;
  - both negative → use the magnitude result reversed (Lt ⇒ greater);
  - otherwise → use the magnitude result.
- Other modes: less = Lt, equal = Eq, greater = ¬Lt ∧ ¬Eq.
- o_less, o_equal and o_greater are registered outputs. When o_valid = 1, exactly one of them is 1.
- Elastic pipeline:
  - en2 = ¬v2 ∨ i_ready;
  - en1 = ¬v1 ∨ en2;
  - o_ready = en1;
  - on en1, v1 ← i_valid;
  - on en2, v2 ← v1.
- Data registers load only when their stage is enabled and the incoming valid is 1.
- i_data_a, i_data_b and i_mode are sampled together at acceptance. A mode change between transactions takes effect per transaction, with no bubbles.

## Timing
- Reset values: o_valid = 0, o_less = 0, o_equal = 0, o_greater = 0, all internal valids and flags = 0.
- o_ready is 1 from the first cycle after reset deassertion.
- Latency: a pair accepted at edge N gives o_valid = 1 after edge N+1, provided i_ready was high, i.e. 2 cycles from acceptance.
- Throughput: 1 result per cycle while i_ready = 1.
- With i_ready = 0, the output holds stable. The pipeline absorbs at most one further pair, then o_ready = 0.
- A simultaneous accept and emit in the same cycle loses nothing and duplicates nothing.
- Reset asserted mid-operation drops all in-flight pairs immediately (asynchronously). No result is emitted for them.
- o_valid must not depend combinationally on i_valid. o_ready depends combinationally on i_ready only.

## Structure
- Package comp_pkg:
  - enum comp_mode_e {CMP_UNSIGNED, CMP_SIGNED, CMP_SIGNMAG, CMP_RSVD};
  - constant default CHUNK = 4;
  - function cdiv(a, b) for the chunk count.
- Sub-module comp_chunk #(CHUNK): combinational per-chunk less/equal, the generalisation of the 4-bit chunk compare. It is instantiated NCHUNK times with a generate loop.
- Stage-2 resolve and the handshake live in comp_pipe.

## Test plan
- Unsigned, SIZE_DATA = 28: A = 0x0FFFFFF, B = 0x1000000 → less = 1 at 2 cycles after acceptance. A = B = 0xABCDEF0 → equal = 1.
- Two's complement: A = 0x8000000 (most negative), B = 0x0000001 → less = 1. A = 0xFFFFFFF (−1), B = 0xFFFFFFE (−2) → greater = 1.
- Sign-magnitude:
  - A = 0x8000000 (−0), B = 0x0000000 → equal = 1;
  - A = 0x8000005, B = 0x8000003 → less = 1;
  - A = 0x0000001, B = 0x8000009 → greater = 1.
- Non-multiple width, SIZE_DATA = 27, CHUNK = 4: A = 0x4000000, B = 0x3FFFFFF, unsigned → greater = 1.
- Backpressure: stream 5 pairs with i_ready toggling 1,0,0,1,… → results arrive in order with none lost or duplicated, outputs stay stable while i_ready = 0, and o_ready drops after 2 pairs are held.
- Reset: assert i_rst_n = 0 while both stages are valid → o_valid = 0 and all flags 0 immediately. After release, the first new pair gives its result 2 cycles after acceptance, with no stale output.
